// File: rtl/apb_manyservs_master.sv
`default_nettype none
// ============================================================================
// Module : apb_manyservs_master
// Brief  : Turns a valid/ready command stream into single APB transfers toward
//          the many-servs cluster CSR port and returns one response per command.
// Rev    : 1.0
// ============================================================================
module apb_manyservs_master #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [31:0]      cmd_addr,
  input  logic [31:0]      cmd_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic             rsp_timeout,
  output logic [31:0]      paddr,
  output logic             psel,
  output logic             penable,
  output logic             pwrite,
  output logic [31:0]      pwdata,
  input  logic [31:0]      prdata,
  input  logic             pready,
  input  logic             perr,
  output logic             busy,
  output logic [CNT_W-1:0] txn_count
);

  localparam int            TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit            TO_EN  = (TIMEOUT != 0);
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TW-1:0] T_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             psel_q, psel_d;
  logic             penable_q, penable_d;
  logic             pwrite_q, pwrite_d;
  logic [31:0]      paddr_q, paddr_d;
  logic [31:0]      pwdata_q, pwdata_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;
  logic             rsp_to_q, rsp_to_d;
  logic [CNT_W-1:0] txn_q, txn_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_to_d    = rsp_to_q;
    txn_d       = txn_q;
    tcnt_d      = tcnt_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          paddr_d  = cmd_addr & 32'hFFFF_FFFC;
          pwrite_d = cmd_write;
          pwdata_d = cmd_write ? cmd_wdata : 32'h0;
          psel_d   = 1'b1;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        tcnt_d    = '0;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        // pready is checked first so a completion on the last allowed cycle wins
        if (pready) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_rdata_d = (!pwrite_q && !perr) ? prdata : 32'h0;
          rsp_err_d   = perr;
          rsp_to_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (TO_EN && (tcnt_q == T_LAST)) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b1;
          rsp_to_d    = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (tcnt_q != T_MAX) begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          txn_d       = txn_q + CNT_W'(1);
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= 32'h0;
      pwdata_q    <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
      txn_q       <= '0;
      tcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_to_q    <= rsp_to_d;
      txn_q       <= txn_d;
      tcnt_q      <= tcnt_d;
    end
  end

  assign cmd_ready   = (state_q == S_IDLE) && !rst;
  assign busy        = (state_q != S_IDLE);
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_to_q;
  assign txn_count   = txn_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_manyservs_master.sv
`default_nettype none
// ============================================================================
// Module : tb_apb_manyservs_master
// Brief  : Table-driven plus randomized bench for apb_manyservs_master with an
//          APB slave model and a transaction-level response model.
// Rev    : 1.0
// ============================================================================
module tb_apb_manyservs_master;

  localparam int TO = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0]   cmd_addr = 32'h0, cmd_wdata = 32'h0;
  logic          rsp_valid, rsp_ready = 1'b0;
  logic [31:0]   rsp_rdata;
  logic          rsp_err, rsp_timeout;
  logic [31:0]   paddr, pwdata;
  logic          psel, penable, pwrite;
  logic [31:0]   prdata = 32'h0;
  logic          pready = 1'b0, perr = 1'b0;
  logic          busy;
  logic [CW-1:0] txn_count;

  apb_manyservs_master #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .perr(perr),
    .busy(busy), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [CW-1:0] exp_cnt  = '0;

  // rdy: ACCESS cycle (1-based) on which the slave raises pready; 0 = never
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    int          rdy;
    bit          perr;
    int          hold;
    logic [31:0] e_rdata;
    bit          e_err;
    bit          e_to;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic vec_t model(input vec_t v);
    vec_t r;
    r       = v;
    r.e_to  = (v.rdy == 0) || (v.rdy > TO);
    r.e_err = r.e_to || v.perr;
    r.e_rdata = (r.e_to || v.wr || v.perr) ? 32'h0 : v.prdata;
    return r;
  endfunction

  task automatic run(input vec_t v);
    logic [31:0] ea, ed;
    int          k;
    bit          done;
    ea = v.addr & 32'hFFFF_FFFC;
    ed = v.wr ? v.wdata : 32'h0;
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
    pready = 1'($urandom);
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
    chk("setup_sel_en", 32'({psel, penable}), 32'b10);
    chk("setup_paddr", paddr, ea);
    chk("setup_pwdata", pwdata, ed);
    chk("setup_pwrite", 32'(pwrite), 32'(v.wr));
    chk("setup_cmd_ready_busy", 32'({cmd_ready, busy}), 32'b01);
    k = 0; done = 1'b0;
    while (!done) begin
      @(posedge clk); #1;
      k++;
      chk("access_sel_en", 32'({psel, penable, rsp_valid}), 32'b110);
      chk("access_paddr_pwdata", paddr ^ {pwdata[15:0], pwdata[31:16]},
          ea ^ {ed[15:0], ed[31:16]});
      chk("access_pwrite", 32'(pwrite), 32'(v.wr));
      pready = (k == v.rdy);
      perr   = pready ? v.perr : 1'($urandom);
      prdata = pready ? v.prdata : $urandom;
      done   = (k == v.rdy) || (k == TO);
    end
    @(posedge clk); #1;
    pready = 1'($urandom); perr = 1'($urandom); prdata = $urandom;
    chk("resp_sel_en", 32'({psel, penable}), 32'b00);
    chk("resp_valid", 32'(rsp_valid), 32'd1);
    chk("resp_rdata", rsp_rdata, v.e_rdata);
    chk("resp_err_to", 32'({rsp_err, rsp_timeout}), 32'({v.e_err, v.e_to}));
    if (v.hold > 0) begin
      cmd_valid = 1'b1; cmd_addr = $urandom; cmd_write = 1'($urandom);
    end
    for (int i = 0; i < v.hold; i++) begin
      @(posedge clk); #1;
      pready = 1'($urandom); perr = 1'($urandom); prdata = $urandom;
      chk("hold_valid_ready_sel", 32'({rsp_valid, cmd_ready, psel}), 32'b100);
      chk("hold_rdata", rsp_rdata, v.e_rdata);
      chk("hold_err_to", 32'({rsp_err, rsp_timeout}), 32'({v.e_err, v.e_to}));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0; cmd_valid = 1'b0; pready = 1'b0;
    exp_cnt = exp_cnt + CW'(1);
    chk("done_valid_busy_sel", 32'({rsp_valid, busy, psel}), 32'b000);
    chk("done_txn_count", 32'(txn_count), 32'(exp_cnt));
    chk("done_paddr_kept", paddr, ea);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    int   r;
    tbl[0] = '{1'b1, 32'h0000_0004, 32'hDEADBEEF, 32'h0,        1,  1'b0, 0, 32'h0,        1'b0, 1'b0};
    tbl[1] = '{1'b0, 32'h0000_0006, 32'h0,        32'h12345678, 3,  1'b0, 0, 32'h12345678, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 32'h0000_0008, 32'h0,        32'hFFFFFFFF, 1,  1'b1, 0, 32'h0,        1'b1, 1'b0};
    tbl[3] = '{1'b0, 32'h0000_000C, 32'h0,        32'hCAFE0000, 0,  1'b0, 1, 32'h0,        1'b1, 1'b1};
    tbl[4] = '{1'b0, 32'h0000_0010, 32'h0,        32'h0A5A5A5A, 16, 1'b0, 0, 32'h0A5A5A5A, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 32'h0000_0013, 32'h0,        32'h00000055, 17, 1'b0, 0, 32'h0,        1'b1, 1'b1};
    tbl[6] = '{1'b1, 32'h0000_0020, 32'h11112222, 32'h00000077, 2,  1'b0, 5, 32'h0,        1'b0, 1'b0};
    tbl[7] = '{1'b0, 32'h0000_0024, 32'h00000099, 32'h87654321, 1,  1'b0, 0, 32'h87654321, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 32'h0000_0028, 32'h00000001, 32'h000000FF, 1,  1'b1, 0, 32'h0,        1'b1, 1'b0};

    #2 rst = 1'b1;
    #1;
    chk("reset_ctrl", 32'({psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout, busy, cmd_ready}), 32'h0);
    chk("reset_paddr_pwdata", paddr | pwdata, 32'h0);
    chk("reset_rdata", rsp_rdata, 32'h0);
    chk("reset_txn_count", 32'(txn_count), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    chk("reset_cmd_ready_held", 32'(cmd_ready), 32'h0);
    rst = 1'b0;
    #1;

    for (int i = 0; i < 9; i++) run(tbl[i]);

    // reset in the middle of an ACCESS phase
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0100;
    @(posedge clk); #1;
    cmd_valid = 1'b0; pready = 1'b0;
    @(posedge clk); #1;
    chk("midrst_in_access", 32'({psel, penable, busy}), 32'b111);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ctrl", 32'({psel, penable, busy, rsp_valid, cmd_ready}), 32'h0);
    chk("midrst_paddr", paddr, 32'h0);
    chk("midrst_txn_count", 32'(txn_count), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = '0;
    #1;
    run(model('{1'b1, 32'h0000_0040, 32'hA5A5_0F0F, 32'h0, 2, 1'b0, 0, 32'h0, 1'b0, 1'b0}));

    for (int n = 0; n < 30; n++) begin
      v.wr     = 1'($urandom);
      v.addr   = $urandom;
      v.wdata  = $urandom;
      v.prdata = $urandom;
      r        = int'($urandom_range(0, 9));
      v.rdy    = (r < 6) ? int'($urandom_range(1, 4)) : (r < 8) ? int'($urandom_range(14, 18)) : 0;
      v.perr   = ($urandom_range(0, 3) == 0);
      v.hold   = int'($urandom_range(0, 3));
      v.e_rdata = 32'h0; v.e_err = 1'b0; v.e_to = 1'b0;
      run(model(v));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
